// File: rtl/ps2_host_tx_if.sv
// Command-side handshake of the PS/2 host transmitter.
// The requester drives a byte and a start strobe. It gets back busy and the done/error pulses.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       done;
  logic       error;

  modport master (output tx_data, output tx_start, input busy, input done, input error);
  modport slave  (input tx_data, input tx_start, output busy, output done, output error);
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. It inhibits the clock, requests to send, and clocks out
// start, D0..D7, odd parity and stop on device falling edges. It then checks the device ack.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int RTS_CYCLES     = 50,
  parameter int START_TIMEOUT  = 750000,
  parameter int FRAME_TIMEOUT  = 100000,
  parameter int FILTER_LEN     = 8
) (
  input  logic         clk,
  input  logic         reset,
  ps2_host_tx_if.slave bus,
  inout  wire          ps2_clk,
  inout  wire          ps2_data
);
  localparam int TW = $clog2(INHIBIT_CYCLES + RTS_CYCLES + START_TIMEOUT + FRAME_TIMEOUT + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    RTS       = 3'd2,
    SEND      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  logic          clk_meta_r, clk_sync_r, data_meta_r, data_sync_r;
  logic          filt_clk_r, filt_prev_r;
  logic [FW-1:0] filt_cnt_r;
  logic          fall_s;
  logic          timeout_s;

  state_t        state_r;
  logic [TW-1:0] timer_r;
  logic [3:0]    k_r;
  logic [9:0]    frame_r;
  logic          clk_oe_r, data_oe_r, busy_r, done_r, error_r;

  // Two-flop synchronizers for both bus lines; the idle level is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      clk_meta_r  <= ps2_clk;
      clk_sync_r  <= clk_meta_r;
      data_meta_r <= ps2_data;
      data_sync_r <= data_meta_r;
    end
  end

  // Glitch filter: the filtered clock follows only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_clk_r  <= 1'b1;
      filt_prev_r <= 1'b1;
      filt_cnt_r  <= FW'(0);
    end else begin
      filt_prev_r <= filt_clk_r;
      if (clk_sync_r == filt_clk_r) begin
        filt_cnt_r <= FW'(0);
      end else if (filt_cnt_r == FW'(FILTER_LEN - 1)) begin
        filt_clk_r <= clk_sync_r;
        filt_cnt_r <= FW'(0);
      end else begin
        filt_cnt_r <= filt_cnt_r + FW'(1);
      end
    end
  end

  assign fall_s = filt_prev_r & ~filt_clk_r;

  // Start timeout applies before the first edge; the frame timeout is counted from that edge.
  always_comb begin
    timeout_s = 1'b0;
    case (state_r)
      SEND:           timeout_s = (k_r == 4'd0) ? (timer_r == TW'(START_TIMEOUT - 1))
                                                : (timer_r == TW'(FRAME_TIMEOUT - 1));
      ACK, WAIT_IDLE: timeout_s = (timer_r == TW'(FRAME_TIMEOUT - 1));
      default:        timeout_s = 1'b0;
    endcase
  end

  // Transmit sequencer with registered line enables and status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      timer_r   <= TW'(0);
      k_r       <= 4'd0;
      frame_r   <= 10'd0;
      clk_oe_r  <= 1'b0;
      data_oe_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      error_r   <= 1'b0;
    end else begin
      done_r  <= 1'b0;
      error_r <= 1'b0;
      if (timeout_s) begin
        clk_oe_r  <= 1'b0;
        data_oe_r <= 1'b0;
        error_r   <= 1'b1;
        busy_r    <= 1'b0;
        state_r   <= IDLE;
      end else begin
        case (state_r)
          IDLE: begin
            clk_oe_r  <= 1'b0;
            data_oe_r <= 1'b0;
            if (bus.tx_start) begin
              frame_r  <= {1'b1, odd_parity(bus.tx_data), bus.tx_data};
              timer_r  <= TW'(0);
              k_r      <= 4'd0;
              clk_oe_r <= 1'b1;
              busy_r   <= 1'b1;
              state_r  <= INHIBIT;
            end
          end
          INHIBIT: begin
            if (timer_r == TW'(INHIBIT_CYCLES - 1)) begin
              data_oe_r <= 1'b1;
              timer_r   <= TW'(0);
              state_r   <= RTS;
            end else begin
              timer_r <= timer_r + TW'(1);
            end
          end
          RTS: begin
            if (timer_r == TW'(RTS_CYCLES - 1)) begin
              clk_oe_r <= 1'b0;
              timer_r  <= TW'(0);
              k_r      <= 4'd0;
              state_r  <= SEND;
            end else begin
              timer_r <= timer_r + TW'(1);
            end
          end
          SEND: begin
            if (fall_s) begin
              // frame_r holds the bits still to go, LSB next; the stop bit releases the line.
              data_oe_r <= ~frame_r[0];
              frame_r   <= {1'b0, frame_r[9:1]};
              k_r       <= k_r + 4'd1;
              timer_r   <= (k_r == 4'd0) ? TW'(0) : timer_r + TW'(1);
              if (k_r == 4'd9) begin
                state_r <= ACK;
              end
            end else begin
              timer_r <= timer_r + TW'(1);
            end
          end
          ACK: begin
            timer_r <= timer_r + TW'(1);
            if (fall_s) begin
              if (!data_sync_r) begin
                state_r <= WAIT_IDLE;
              end else begin
                clk_oe_r  <= 1'b0;
                data_oe_r <= 1'b0;
                error_r   <= 1'b1;
                busy_r    <= 1'b0;
                state_r   <= IDLE;
              end
            end
          end
          WAIT_IDLE: begin
            if (filt_clk_r && data_sync_r) begin
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= IDLE;
            end else begin
              timer_r <= timer_r + TW'(1);
            end
          end
          default: begin
            clk_oe_r  <= 1'b0;
            data_oe_r <= 1'b0;
            busy_r    <= 1'b0;
            state_r   <= IDLE;
          end
        endcase
      end
    end
  end

  assign ps2_clk  = clk_oe_r  ? 1'b0 : 1'bz;
  assign ps2_data = data_oe_r ? 1'b0 : 1'bz;

  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.error = error_r;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the host.
// Each frame is compared with a wire-level model built from the byte.
module tb_ps2_host_tx;
  localparam int INH  = 20;
  localparam int RTSC = 4;
  localparam int STO  = 400;
  localparam int FTO  = 2000;
  localparam int FLT  = 4;
  localparam int HALF = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  wire  ps2_clk, ps2_data;
  bit   abort = 1'b0;
  int   err_cnt = 0;
  int   chk_cnt = 0;
  int   cyc = 0;
  int   fall11_cyc = 0;
  int   pulse_cyc = 0;

  ps2_host_tx_if bus();

  pullup pu_clk  (ps2_clk);
  pullup pu_data (ps2_data);
  assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
  assign ps2_data = dev_data_low ? 1'b0 : 1'bz;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH), .RTS_CYCLES(RTSC), .START_TIMEOUT(STO),
    .FRAME_TIMEOUT(FTO), .FILTER_LEN(FLT)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .ps2_clk(ps2_clk), .ps2_data(ps2_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wire order: bit i is the i-th bit seen on the data line (start, D0..D7, parity, stop).
  function automatic logic [10:0] frame_model(input logic [7:0] b);
    logic p;
    p = (($countones(b) % 2) == 0);
    return {1'b1, p, b, 1'b0};
  endfunction

  task automatic measure(output int lowc, output int dat);
    lowc = 0;
    dat  = -1;
    while (ps2_clk === 1'b0 && lowc < 200) begin
      if (ps2_data === 1'b0 && dat < 0) dat = lowc;
      lowc++;
      @(negedge clk);
    end
  endtask

  task automatic monitor(input int budget, output int nd, output int ne, output int idx,
                         output logic busy_at);
    nd = 0; ne = 0; idx = -1; busy_at = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (bus.done === 1'b1) nd++;
      if (bus.error === 1'b1) ne++;
      if ((bus.done === 1'b1 || bus.error === 1'b1) && idx < 0) begin
        idx = i;
        busy_at = bus.busy;
        pulse_cyc = cyc;
      end
      if (idx >= 0 && i >= idx + 30) break;
      if (abort) break;
      @(negedge clk);
    end
  endtask

  task automatic device(input bit do_ack, input int glitch_pulse, input int reset_pulse,
                        input logic [10:0] exp_bits, output logic [10:0] bits, output bit ok);
    int n;
    bits = 11'd0;
    ok = 1'b0;
    n = 0;
    @(negedge clk);
    while (!(ps2_clk === 1'b1 && ps2_data === 1'b0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) return;
    repeat (10) @(negedge clk);
    bits[0] = ps2_data;
    for (int j = 1; j <= 10; j++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      @(negedge clk);
      bits[j] = ps2_data;
      if (j == reset_pulse) begin
        check_val("rst pre data", bits[j], exp_bits[j]);
        reset = 1'b1;
        #1;
        check_val("rst clk line", ps2_clk, 1);
        check_val("rst data line", ps2_data, 1);
        check_val("rst busy", bus.busy, 0);
        check_val("rst done", bus.done, 0);
        check_val("rst error", bus.error, 0);
        abort = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (j == glitch_pulse) begin
        repeat (8) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (2) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (HALF - 11) @(negedge clk);
      end else begin
        repeat (HALF - 1) @(negedge clk);
      end
    end
    if (do_ack) dev_data_low = 1'b1;
    repeat (5) @(negedge clk);
    fall11_cyc = cyc;
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (5) @(negedge clk);
    dev_data_low = 1'b0;
    ok = 1'b1;
  endtask

  task automatic send(input string name, input logic [7:0] b, input bit dev_on, input bit do_ack,
                      input int glitch_pulse, input int reset_pulse, input bit extra_start,
                      input bit chk_timing);
    logic [10:0] bits, exp_bits;
    bit ok;
    int nd, ne, idx, lowc, dat;
    logic busy_at;
    exp_bits = frame_model(b);
    bits = 11'd0;
    ok = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    bus.tx_data = b;
    bus.tx_start = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
    check_val({name, " busy after start"}, bus.busy, 1);
    check_val({name, " clk inhibited"}, ps2_clk, 0);
    fork
      monitor(3000, nd, ne, idx, busy_at);
      measure(lowc, dat);
      begin
        if (dev_on) device(do_ack, glitch_pulse, reset_pulse, exp_bits, bits, ok);
      end
      begin
        if (extra_start) begin
          repeat (30) @(negedge clk);
          bus.tx_data = 8'h00;
          bus.tx_start = 1'b1;
          @(negedge clk);
          bus.tx_start = 1'b0;
        end
      end
    join
    if (chk_timing) begin
      check_val({name, " clk low cycles"}, lowc, INH + RTSC);
      check_val({name, " data low offset"}, dat, INH);
    end
    if (reset_pulse > 0) begin
      check_val({name, " no done"}, nd, 0);
      check_val({name, " no error"}, ne, 0);
      return;
    end
    if (!dev_on) begin
      check_val({name, " error count"}, ne, 1);
      check_val({name, " done count"}, nd, 0);
      check_val({name, " error time ok"}, (idx >= INH + RTSC + STO - 1 && idx <= INH + RTSC + STO + 1), 1);
    end else if (do_ack) begin
      check_val({name, " device ran"}, ok, 1);
      check_val({name, " bits"}, bits, exp_bits);
      check_val({name, " done count"}, nd, 1);
      check_val({name, " error count"}, ne, 0);
    end else begin
      check_val({name, " bits"}, bits, exp_bits);
      check_val({name, " error count"}, ne, 1);
      check_val({name, " done count"}, nd, 0);
      check_val({name, " error after edge11"}, (pulse_cyc > fall11_cyc), 1);
    end
    check_val({name, " busy low at pulse"}, busy_at, 0);
    @(negedge clk);
    check_val({name, " clk released"}, ps2_clk, 1);
    check_val({name, " data released"}, ps2_data, 1);
    check_val({name, " idle busy"}, bus.busy, 0);
  endtask

  initial begin
    logic [7:0] rb;
    bus.tx_data = 8'h00;
    bus.tx_start = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_val("reset busy", bus.busy, 0);
    check_val("reset done", bus.done, 0);
    check_val("reset error", bus.error, 0);
    check_val("reset clk line", ps2_clk, 1);
    check_val("reset data line", ps2_data, 1);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    send("f4", 8'hF4, 1'b1, 1'b1, 0, 0, 1'b0, 1'b1);
    send("ff", 8'hFF, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
    send("nodev", 8'h5A, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    send("noack", 8'hA5, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    send("glitch", 8'h3C, 1'b1, 1'b1, 4, 0, 1'b0, 1'b0);
    send("arb", 8'h96, 1'b1, 1'b1, 0, 0, 1'b1, 1'b0);
    send("rst", 8'h0F, 1'b1, 1'b1, 0, 5, 1'b0, 1'b0);
    send("post rst", 8'hF4, 1'b1, 1'b1, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      rb = 8'($urandom_range(255, 0));
      send("rand", rb, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte, such as 0xFF (reset) or 0xF4 (enable reporting), to a keyboard or mouse over the shared open-drain ps2_clk/ps2_data pair. It sits beside each PS/2 receiver in the devices layer and drives the same bidirectional pins. The receiver uses `busy` to ignore line activity while a host frame is in flight.

## Interface
Parameters:
- INHIBIT_CYCLES, 5000: clock-low inhibit time (100 µs at 50 MHz).
- RTS_CYCLES, 50: data-low overlap with the inhibited clock before the clock is released.
- START_TIMEOUT, 750000: maximum wait from clock release to the device's first falling edge (15 ms).
- FRAME_TIMEOUT, 100000: maximum time from the first falling edge to the ack edge (2 ms).
- FILTER_LEN, 8: number of consecutive equal samples the ps2_clk glitch filter needs before it changes.

Ports:
- clk, input, 1: system clock. One clock domain.
- reset, input, 1: asynchronous, active-high reset.
- tx_data, input, 8: byte to send, LSB first.
- tx_start, input, 1: single-cycle request. Accepted only when busy=0.
- busy, output, 1: high from the cycle after acceptance until the done/error pulse.
- done, output, 1: one-cycle pulse when the device has acknowledged the byte.
- error, output, 1: one-cycle pulse on a timeout or a missing ack.
- ps2_clk, inout, 1: open-drain. The block drives 0 or z only.
- ps2_data, inout, 1: open-drain. The block drives 0 or z only.

## Operation
Input conditioning:
- ps2_clk and ps2_data each pass through a 2-FF synchronizer.
- The synchronized clock feeds a filter that takes the new level only after FILTER_LEN identical consecutive samples.
- `fall` is a one-cycle pulse on a filtered 1→0 transition.

Pin drive:
- ps2_clk = clk_oe ? 0 : z.
- ps2_data = data_oe ? 0 : z.

State machine:
- IDLE: both lines released.
  - When tx_start=1, latch tx_data, compute parity = ~^tx_data (odd parity), clear counters, go to INHIBIT.
- INHIBIT: clk_oe=1, data_oe=0 for INHIBIT_CYCLES cycles, then go to RTS.
- RTS: clk_oe=1, data_oe=1 for RTS_CYCLES cycles. Driving data low here is the start bit.
  - Then release the clock (clk_oe=0), keep data_oe=1, clear the timer, edge count k=0, go to SEND.
- SEND: on each `fall`, increment k and present the next bit.
  - k=1..8: data bits 0..7.
  - k=9: parity.
  - k=10: stop bit, data released.
  - data_oe = ~bit.
  - After k=10, go to ACK.
- ACK: on the next `fall`, sample synchronized ps2_data.
  - 0: go to WAIT_IDLE.
  - 1: error.
- WAIT_IDLE: wait until the filtered clock and synchronized data are both 1, then pulse done and go to IDLE.

Timeouts and errors:
- While in SEND with k=0, the timer reaching START_TIMEOUT is an error.
- From the first `fall` through ACK, the timer reaching FRAME_TIMEOUT is an error. The timer resets once at the first `fall` and is not reset per edge.
- WAIT_IDLE is also bounded by FRAME_TIMEOUT, counted from the first `fall`.
- Error path: release both lines in the same cycle, pulse error, drop busy, go to IDLE.

Arbitration and reset:
- tx_start while busy=1 is ignored, and tx_data is not re-latched.
- reset asserted at any point, including mid-frame: immediately go to IDLE and release both lines. busy=0, done=0, error=0. No pulse is emitted.

## Timing
- Reset values: busy=0, done=0, error=0, clk_oe=0, data_oe=0, all counters 0, filtered clock=1.
- Acceptance:
  - busy=1 and clk_oe=1 in the cycle after tx_start.
  - The clock is low for exactly INHIBIT_CYCLES+RTS_CYCLES cycles.
  - data_oe rises exactly INHIBIT_CYCLES cycles after clk_oe rises.
- Bit update latency: the data line changes 1 cycle after `fall`. `fall` itself lags the pin edge by 2 synchronizer cycles plus FILTER_LEN cycles.
- done/error:
  - Registered, exactly one cycle wide, mutually exclusive.
  - busy falls in the same cycle the pulse is high.
  - A new tx_start is accepted from the following cycle.
- Line state: an 11-bit frame on the wire — start 0, D0..D7, P, stop 1 — followed by the device ack 0.

## Test plan
Use INHIBIT_CYCLES=20, RTS_CYCLES=4, START_TIMEOUT=400, FRAME_TIMEOUT=2000, FILTER_LEN=4, and a behavioural device model clocking at a 40-cycle period.
- Send 0xF4 with the device acking. Required:
  - Sampled bits are 0,0,0,1,0,1,1,1,1,0,1 (start, D0..D7, P=0, stop).
  - done pulses once, error stays 0, both lines are z afterwards.
- Send 0xFF with the device acking. Required: parity samples 1, stop samples 1, done pulses.
- No device (pull-ups only). Required: error pulses exactly 20+4+400 cycles after acceptance (±1 for the registered pulse), busy drops, lines are released.
- Device leaves data high at the ack edge. Required: error pulses after the 11th falling edge, done stays 0.
- Noise and arbitration:
  - A 2-cycle low glitch on ps2_clk during SEND is ignored; the bit index is unchanged and the byte completes correctly.
  - A second tx_start of 0x00 while busy is ignored; only the first byte is transmitted.
- Reset asserted at edge k=5. Required: lines are z in the same cycle, busy=done=error=0, and a subsequent 0xF4 send completes normally.
